// File: rtl/acc_bank_pkg.sv
// acc_bank_pkg: shared definitions for accumulator_bank.
//   DEF_*           default configuration (N=10, Q=9, CH=4, G=3, saturating)
//   ch_width()      channel index width, never below 1 bit
//   acc_width()     internal accumulator width (data width plus guard bits)
//   CHW, AW         widths for the default configuration
//   ACC_MAX/ACC_MIN internal accumulator range for the default configuration
//   OUT_MAX/OUT_MIN output range for the default configuration
//   sat_clamp()     clamps a wide signed value to a signed width and reports
//                   whether the value had to be clamped
package acc_bank_pkg;

  localparam int DEF_N   = 10;
  localparam int DEF_Q   = 9;
  localparam int DEF_CH  = 4;
  localparam int DEF_G   = 3;
  localparam int DEF_SAT = 1;

  function automatic int ch_width(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

  function automatic int acc_width(input int n, input int g);
    return n + g;
  endfunction

  localparam int CHW = ch_width(DEF_CH);
  localparam int AW  = acc_width(DEF_N, DEF_G);

  localparam longint ACC_MAX = (longint'(1) <<< (AW - 1)) - 1;
  localparam longint ACC_MIN = -ACC_MAX - 1;
  localparam longint OUT_MAX = (longint'(1) <<< (DEF_N - 1)) - 1;
  localparam longint OUT_MIN = -OUT_MAX - 1;

  typedef struct packed {
    logic signed [63:0] value;
    logic               flag;
  } clamp_t;

  // Inputs are at most a few bits wider than the target width, so a 64-bit
  // working width covers every legal configuration.
  function automatic clamp_t sat_clamp(input logic signed [63:0] value, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    clamp_t             res;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) begin
      res.value = hi;
      res.flag  = 1'b1;
    end else if (value < lo) begin
      res.value = lo;
      res.flag  = 1'b1;
    end else begin
      res.value = value;
      res.flag  = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/accumulator_bank_lane.sv
// acc_lane: one channel of accumulator_bank.
//   clk, rst_n  clock, asynchronous active-low reset
//   en          an accepted beat targets this channel
//   first/last  run framing of the current beat
//   data        signed addend
//   res_data    output-width result computed from this beat's sum
//   res_ovf     overflow flag that goes with res_data
// The result outputs are valid whenever a beat is presented; the top only
// captures them on an emit.
module acc_lane
  import acc_bank_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int G   = DEF_G,
  parameter int SAT = DEF_SAT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                first,
  input  logic                last,
  input  logic signed [N-1:0] data,
  output logic signed [N-1:0] res_data,
  output logic                res_ovf
);

  localparam int LAW = acc_width(N, G);

  logic signed [LAW-1:0] acc_q, acc_d, next_acc;
  logic                  ovf_q, ovf_d, ovf_next;
  logic signed [63:0]    sum;
  clamp_t                acc_c, out_c;
  logic                  unused_hi;

  always_comb begin
    // A first beat loads rather than adds and starts with a clean flag.
    sum      = first ? 64'(data) : 64'(acc_q) + 64'(data);
    acc_c    = sat_clamp(sum, LAW);
    ovf_next = (ovf_q & ~first) | acc_c.flag;
    next_acc = (SAT != 0) ? acc_c.value[LAW-1:0] : sum[LAW-1:0];
    out_c    = sat_clamp(64'(next_acc), N);
    res_data = (SAT != 0) ? out_c.value[N-1:0] : next_acc[N-1:0];
    res_ovf  = ovf_next | out_c.flag;
    // Upper bits only mirror the sign after clamping.
    unused_hi = ^{acc_c.value[63:LAW], out_c.value[63:N]};

    acc_d = acc_q;
    ovf_d = ovf_q;
    if (en) begin
      if (last) begin
        acc_d = '0;
        ovf_d = 1'b0;
      end else begin
        acc_d = next_acc;
        ovf_d = ovf_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: rtl/accumulator_bank.sv
// accumulator_bank: CH independent guarded accumulators with a shared
// one-entry valid/ready result register.
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid/in_ready             input beat handshake
//   in_data, in_ch                signed addend and target channel
//   in_first, in_last             run framing (load / emit)
//   out_valid/out_ready           result handshake
//   out_data, out_ch, out_ovf     result, its channel, run overflow flag
// Channels at or above CH are accepted and ignored.
module accumulator_bank
  import acc_bank_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int Q   = DEF_Q,
  parameter int CH  = DEF_CH,
  parameter int G   = DEF_G,
  parameter int SAT = DEF_SAT,
  localparam int CW = ch_width(CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] in_data,
  input  logic [CW-1:0]       in_ch,
  input  logic                in_first,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] out_data,
  output logic [CW-1:0]       out_ch,
  output logic                out_ovf
);

  // Q only documents the number format; nothing is rescaled here.
  if (Q < 0 || Q >= N || CH < 1) begin : g_bad_cfg
    $error("accumulator_bank: need 0 <= Q < N and CH >= 1");
  end

  logic                out_valid_q, out_valid_d;
  logic signed [N-1:0] out_data_q, out_data_d;
  logic [CW-1:0]       out_ch_q, out_ch_d;
  logic                out_ovf_q, out_ovf_d;

  logic                accept, emit, ch_ok;
  logic signed [N-1:0] lane_data [CH];
  logic                lane_ovf  [CH];
  logic signed [N-1:0] sel_data;
  logic                sel_ovf;

  for (genvar i = 0; i < CH; i++) begin : g_lane
    acc_lane #(
      .N  (N),
      .G  (G),
      .SAT(SAT)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (accept && (in_ch == CW'(i))),
      .first   (in_first),
      .last    (in_last),
      .data    (in_data),
      .res_data(lane_data[i]),
      .res_ovf (lane_ovf[i])
    );
  end

  always_comb begin
    // A pending result blocks every channel so nothing can overwrite it.
    in_ready = !out_valid_q || out_ready;
    accept   = in_valid && in_ready;
    ch_ok    = 32'(in_ch) < CH;
    emit     = accept && in_last && ch_ok;

    sel_data = '0;
    sel_ovf  = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (in_ch == CW'(i)) begin
        sel_data = lane_data[i];
        sel_ovf  = lane_ovf[i];
      end
    end

    // An emit during an output handshake replaces the entry in place.
    out_valid_d = emit || (out_valid_q && !out_ready);
    out_data_d  = emit ? sel_data : out_data_q;
    out_ch_d    = emit ? in_ch    : out_ch_q;
    out_ovf_d   = emit ? sel_ovf  : out_ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_ovf   = out_ovf_q;

endmodule
